mp2d_preimage_search: RTL and testbench

Sequential sweeper that drives the 14-bit input bus of an mp2d PLA instance and reads its 14-bit output bus back. It enumerates all 2^14 input vectors and streams every vector whose output matches a masked target, then reports the total match count. This is the reverse mapping of the PLA, output to inputs. It sits beside the PLA core in the characterisation/self-test path.

---
 rtl/mp2d_pkg.sv | 18 +
 rtl/mp2d_preimage_search_if.sv | 33 +++
 rtl/mp2d_match_slot.sv | 51 +++++
 rtl/mp2d_preimage_search.sv | 143 ++++++++++++++
 tb/tb_mp2d_preimage_search.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mp2d_pkg.sv
// Shared types and sizes for the mp2d preimage sweeper.
package mp2d_pkg;

  localparam int MP2D_W  = 14;
  localparam int MP2D_CW = MP2D_W + 1;

  typedef logic [MP2D_W-1:0]  mp2d_x_t;
  typedef logic [MP2D_W-1:0]  mp2d_z_t;
  typedef logic [MP2D_CW-1:0] mp2d_cnt_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } search_state_t;

endpackage

// File: rtl/mp2d_preimage_search_if.sv
// Control, status and match-stream bundle of the preimage sweeper.
// master = the controller / stream consumer, slave = the sweeper itself.
interface mp2d_preimage_search_if
  import mp2d_pkg::*;
#(
  parameter int W  = MP2D_W,
  parameter int CW = W + 1
);

  logic          start;
  logic          abort;
  logic          first_only;
  logic [W-1:0]  target;
  logic [W-1:0]  mask;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [CW-1:0] match_count;
  logic          match_valid;
  logic          match_ready;
  logic [W-1:0]  match_x;

  modport master (
    output start, abort, first_only, target, mask, match_ready,
    input  busy, done, aborted, match_count, match_valid, match_x
  );

  modport slave (
    input  start, abort, first_only, target, mask, match_ready,
    output busy, done, aborted, match_count, match_valid, match_x
  );

endinterface

// File: rtl/mp2d_match_slot.sv
// Single-entry valid/ready output register: load, hold until consumed, flush.
module mp2d_match_slot
  import mp2d_pkg::*;
#(
  parameter int W = MP2D_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         flush_i,
  input  logic         ready_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic         free_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Next-state: flush beats load, load beats the consume of the old beat.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Slot registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  // A new beat may be loaded when the slot is empty or drains this edge.
  assign free_o  = !valid_q || ready_i;

endmodule

// File: rtl/mp2d_preimage_search.sv
// Sweeps every PLA input vector and streams those whose output matches a
// masked target, then reports how many were emitted.
//
// state | meaning
// IDLE  | waiting for start
// SWEEP | driving x_o = cnt, evaluating z_i each cycle
// DRAIN | sweep finished, waiting for the last beat to be consumed
// FIN   | done pulse, back to IDLE
module mp2d_preimage_search
  import mp2d_pkg::*;
#(
  parameter int W  = MP2D_W,
  parameter int CW = W + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [W-1:0]           x_o,
  input  logic [W-1:0]           z_i,
  mp2d_preimage_search_if.slave  ctl
);

  // Terminal compare is on the last vector; cnt never wraps back to 0.
  localparam logic [CW-1:0] LAST_X = CW'((1 << W) - 1);

  search_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  target_q, target_d;
  logic [W-1:0]  mask_q, mask_d;
  logic          first_only_q, first_only_d;
  logic          aborted_q, aborted_d;

  logic          hit;
  logic          slot_load;
  logic          slot_flush;
  logic          slot_valid;
  logic          slot_free;

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      count_q      <= '0;
      target_q     <= '0;
      mask_q       <= '0;
      first_only_q <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      count_q      <= count_d;
      target_q     <= target_d;
      mask_q       <= mask_d;
      first_only_q <= first_only_d;
      aborted_q    <= aborted_d;
    end
  end

  // Next-state and slot control.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    count_d      = count_q;
    target_d     = target_q;
    mask_d       = mask_q;
    first_only_d = first_only_q;
    aborted_d    = aborted_q;
    slot_load    = 1'b0;
    slot_flush   = 1'b0;
    hit          = (((z_i ^ target_q) & mask_q) == '0);

    unique case (state_q)
      S_IDLE: begin
        // abort is deliberately not looked at here: start always wins.
        if (ctl.start) begin
          target_d     = ctl.target;
          mask_d       = ctl.mask;
          first_only_d = ctl.first_only;
          cnt_d        = '0;
          count_d      = '0;
          aborted_d    = 1'b0;
          state_d      = S_SWEEP;
        end
      end
      S_SWEEP: begin
        if (ctl.abort) begin
          slot_flush = 1'b1;
          aborted_d  = 1'b1;
          state_d    = S_FIN;
        end else if (!hit || slot_free) begin
          // A hit with an occupied slot falls through: cnt holds and the
          // same vector is evaluated again next cycle.
          if (hit) begin
            slot_load = 1'b1;
            count_d   = count_q + CW'(1);
          end
          // x_o stays on the final vector rather than advancing past it.
          if (cnt_q == LAST_X || (hit && first_only_q)) begin
            state_d = S_DRAIN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (ctl.abort) begin
          slot_flush = 1'b1;
          aborted_d  = 1'b1;
          state_d    = S_FIN;
        end else if (!slot_valid) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  mp2d_match_slot #(.W(W)) u_slot (
    .clk     (clk),
    .rst     (rst),
    .load_i  (slot_load),
    .flush_i (slot_flush),
    .ready_i (ctl.match_ready),
    .data_i  (x_o),
    .valid_o (slot_valid),
    .free_o  (slot_free),
    .data_o  (ctl.match_x)
  );

  assign x_o             = cnt_q[W-1:0];
  assign ctl.match_valid = slot_valid;
  assign ctl.busy        = (state_q == S_SWEEP) || (state_q == S_DRAIN);
  assign ctl.done        = (state_q == S_FIN);
  assign ctl.match_count = count_q;
  assign ctl.aborted     = aborted_q;

endmodule

// File: tb/tb_mp2d_preimage_search.sv
// Bench for mp2d_preimage_search with a small stand-in PLA. z[7] and z[11]
// are shaped so the matching input sets are easy to derive by hand.
module tb_mp2d_preimage_search;
  import mp2d_pkg::*;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  mp2d_x_t x_o;
  mp2d_z_t z_i;

  always #5 clk = ~clk;

  mp2d_preimage_search_if bus ();

  mp2d_preimage_search dut (
    .clk (clk),
    .rst (rst),
    .x_o (x_o),
    .z_i (z_i),
    .ctl (bus)
  );

  // z7  = x0 & ~x1..x4          -> 512 inputs, 0x0001 .. 0x3FE1
  // z11 = x6..x10 & ~x11 & x12 & ~x13 -> 64 inputs, 0x17C0 .. 0x17FF
  function automatic mp2d_z_t pla(input mp2d_x_t x);
    mp2d_z_t z;
    z     = {x[6:0], x[13:7]} ^ 14'h2A55;
    z[7]  = x[0] & ~(|x[4:1]);
    z[11] = (&x[10:6]) & ~x[11] & x[12] & ~x[13];
    return z;
  endfunction

  assign z_i = pla(x_o);

  int      compared   = 0;
  int      mismatched = 0;
  mp2d_x_t exp_q[$];
  int      ready_mode = 0;
  int      stall_left = 0;
  bit      chk_z11    = 1'b0;
  bit      chk_xhold  = 1'b0;
  bit      prev_valid = 1'b0;
  bit      prev_ready = 1'b0;
  mp2d_x_t prev_x     = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name, input int waited);
    compared++;
    mismatched++;
    $display("FAIL %s: event not seen after %0d cycles", name, waited);
  endtask

  // Reference list of beats: every input whose PLA output matches, in order.
  task automatic build_model(input mp2d_z_t m, input mp2d_z_t t, input bit fo);
    exp_q.delete();
    for (int x = 0; x < (1 << MP2D_W); x++) begin
      if (((pla(mp2d_x_t'(x)) ^ t) & m) == '0) begin
        exp_q.push_back(mp2d_x_t'(x));
        if (fo) break;
      end
    end
  endtask

  // Consumer ready pattern: 0 always, 1 pseudo-random, 2 timed stall, 3 manual.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: bus.match_ready = 1'b1;
        1: bus.match_ready = ($urandom_range(0, 7) != 0);
        2: begin
          bus.match_ready = (stall_left == 0);
          if (stall_left > 0) stall_left--;
        end
        default: ;
      endcase
    end
  end

  // Stream checker: every consumed beat against the reference list, plus
  // hold/stability of a beat that is waiting on ready.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
        continue;
      end
      if (prev_valid && !prev_ready) begin
        check("valid_hold", 32'(bus.match_valid), 32'h1);
        check("x_stable", 32'(bus.match_x), 32'(prev_x));
      end
      if (chk_xhold && bus.match_valid) check("x_hold", 32'(x_o), 32'h1);
      if (bus.match_valid && bus.match_ready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL beat_extra: got 0x%0h, expected no beat", bus.match_x);
        end else begin
          check("beat_x", 32'(bus.match_x), 32'(exp_q.pop_front()));
        end
        if (chk_z11) check("z11_bits", 32'(bus.match_x & 14'h3FC0), 32'h17C0);
      end
      prev_valid = bus.match_valid && !bus.abort;
      prev_ready = bus.match_ready;
      prev_x     = bus.match_x;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_x_o"}, 32'(x_o), 32'h0);
    check({tag, "_valid"}, 32'(bus.match_valid), 32'h0);
    check({tag, "_match_x"}, 32'(bus.match_x), 32'h0);
    check({tag, "_done"}, 32'(bus.done), 32'h0);
    check({tag, "_busy"}, 32'(bus.busy), 32'h0);
    check({tag, "_count"}, 32'(bus.match_count), 32'h0);
    check({tag, "_aborted"}, 32'(bus.aborted), 32'h0);
  endtask

  // One complete run; lit_n and lit_cycles are hand-derived (-1 skips cycles).
  task automatic run(input mp2d_z_t m, input mp2d_z_t t, input bit fo,
                     input int rmode, input int lit_n, input int lit_cycles);
    int n;
    int c;
    bit seen;
    build_model(m, t, fo);
    n = exp_q.size();
    check("model_n", n, lit_n);
    if (rmode == 2) begin
      stall_left      = 12;
      bus.match_ready = 1'b0;
    end
    ready_mode = rmode;
    @(posedge clk);
    #1;
    bus.start      = 1'b1;
    bus.mask       = m;
    bus.target     = t;
    bus.first_only = fo;
    @(posedge clk);
    #1;
    bus.start      = 1'b0;
    bus.mask       = ~m;
    bus.target     = ~t;
    bus.first_only = ~fo;
    check("start_busy", 32'(bus.busy), 32'h1);
    check("start_x0", 32'(x_o), 32'h0);
    seen = 1'b0;
    for (c = 0; c < 40000; c++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      fail_now("done_timeout", c);
    end else begin
      if (lit_cycles >= 0) check("sweep_cycles", c, lit_cycles);
      check("done_count", 32'(bus.match_count), n);
      check("done_aborted", 32'(bus.aborted), 32'h0);
      check("leftover", exp_q.size(), 0);
      @(negedge clk);
      check("done_pulse", 32'(bus.done), 32'h0);
    end
    ready_mode = 0;
  endtask

  initial begin
    bit seen;
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.first_only  = 1'b0;
    bus.mask        = '0;
    bus.target      = '0;
    bus.match_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // z7 target: pin the model, then a full unstalled sweep.
    build_model(14'h0080, 14'h0080, 1'b0);
    check("z07_first", 32'(exp_q[0]), 32'h0001);
    check("z07_last", 32'(exp_q[exp_q.size()-1]), 32'h3FE1);
    run(14'h0080, 14'h0080, 1'b0, 0, 512, 16385);

    // z11 target.
    build_model(14'h0800, 14'h0800, 1'b0);
    check("z11_first", 32'(exp_q[0]), 32'h17C0);
    chk_z11 = 1'b1;
    run(14'h0800, 14'h0800, 1'b0, 0, 64, 16385);
    chk_z11 = 1'b0;

    // Everything matches, consumer stalls at random.
    run(14'h0000, 14'h0000, 1'b0, 1, 16384, -1);

    // first_only with the consumer stalled.
    chk_xhold = 1'b1;
    run(14'h0080, 14'h0080, 1'b1, 2, 1, -1);
    chk_xhold = 1'b0;

    // Abort at cnt=100 with a beat pending; start+abort in IDLE starts.
    build_model(14'h0000, 14'h0000, 1'b0);
    ready_mode = 0;
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    bus.mask  = '0;
    bus.target = '0;
    bus.first_only = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("start_wins_busy", 32'(bus.busy), 32'h1);
    seen = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (x_o == 14'd100) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_now("reach_cnt100", 500);
    check("abort_pending", 32'(bus.match_valid), 32'h1);
    @(posedge clk);
    #1;
    ready_mode      = 3;
    bus.match_ready = 1'b0;
    bus.abort       = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    check("abort_valid_drop", 32'(bus.match_valid), 32'h0);
    check("abort_done", 32'(bus.done), 32'h1);
    check("abort_flag", 32'(bus.aborted), 32'h1);
    check("abort_count", 32'(bus.match_count), 32'd101);
    exp_q.delete();
    ready_mode = 0;
    run(14'h0080, 14'h0080, 1'b1, 0, 1, 4);

    // Reset mid-sweep, with a start while busy that must be ignored.
    build_model(14'h0000, 14'h0000, 1'b0);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.mask  = '0;
    bus.target = '0;
    bus.first_only = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    bus.start  = 1'b1;
    bus.mask   = 14'h0800;
    bus.target = 14'h0800;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("busy_start_ignored", 32'(x_o), 32'd31);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    check("rst_no_done", 32'(bus.done), 32'h0);
    rst = 1'b0;
    chk_z11 = 1'b1;
    run(14'h0800, 14'h0800, 1'b0, 0, 64, 16385);
    chk_z11 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
